// File: rtl/pkt_ingress_pkg.sv
// Shared router definitions: ingress FSM state encoding and drop-cause codes.
package pkt_ingress_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DATA    = 2'd1,
      ST_CRC     = 2'd2,
      ST_DISCARD = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NO_MATCH = 2'b00,
      CAUSE_BAD_LEN  = 2'b01,
      CAUSE_BAD_CRC  = 2'b10
   } drop_cause_t;

endpackage

// File: rtl/pkt_ingress_crc.sv
// Byte-wide serial CRC, MSB first, zero initial value.
// clr restarts the checksum so the byte presented with it is the first one folded in.
module crc_serial #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = 'h07
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] crc
);

   logic [WIDTH-1:0] crc_base;

   function automatic logic [WIDTH-1:0] crc_next(input logic [WIDTH-1:0] c,
                                                 input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      r = c;
      for (int b = WIDTH - 1; b >= 0; b--) begin
         if (r[WIDTH-1] ^ d[b]) r = (r << 1) ^ POLY;
         else                   r = r << 1;
      end
      return r;
   endfunction

   assign crc_base = clr ? '0 : crc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      crc <= '0;
      else if (en)  crc <= crc_next(crc_base, data);
      else if (clr) crc <= '0;
   end

endmodule

// File: rtl/pkt_ingress.sv
// Packet ingress router: decodes a header byte, steers the packet into one channel FIFO,
// optionally checks a trailing CRC, and commits or flushes the packet at its end.
//   state      | meaning
//   ST_IDLE    | waiting for a header byte; channel decoded from data_in
//   ST_DATA    | pushing payload bytes to the latched channel
//   ST_CRC     | comparing the trailer byte against the running CRC
//   ST_DISCARD | swallowing the rest of a dropped packet
module pkt_ingress
   import pkt_ingress_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    SIZE_WIDTH = 6,
   parameter int                    ADDR_WIDTH = 2,
   parameter int                    NUM_CH     = 3,
   parameter logic [DATA_WIDTH-1:0] CRC_POLY   = 'h07,
   parameter int                    DROP_CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH-1:0]        data_in,
   input  logic                         data_in_req,
   output logic                         data_in_ack,
   output logic [NUM_CH-1:0]            fifo_push,
   output logic [NUM_CH-1:0]            fifo_flush,
   output logic [NUM_CH-1:0]            fifo_wr_ptr_upd,
   input  logic [NUM_CH-1:0]            fifo_full,
   output logic [DATA_WIDTH-1:0]        fifo_data_in,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
   input  logic                         crc_en,
   output logic                         pkt_ok,
   output logic                         pkt_drop,
   output logic [1:0]                   drop_cause,
   output logic [DROP_CNT_W-1:0]        drop_cnt
);

   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = SIZE_WIDTH + 1;

   if (DATA_WIDTH < SIZE_WIDTH + ADDR_WIDTH) begin : g_width_check
      $error("pkt_ingress: DATA_WIDTH must hold the length and address fields");
   end

   state_t                state, state_nxt;
   drop_cause_t           cause;
   logic [CNT_W-1:0]      cnt, cnt_nxt, cnt_load;
   logic [SEL_W-1:0]      sel_q, sel_dec, sel_cur;
   logic [NUM_CH-1:0]     ch_onehot;
   logic [SIZE_WIDTH-1:0] hdr_len;
   logic [ADDR_WIDTH-1:0] hdr_addr;
   logic [DATA_WIDTH-1:0] crc_val;
   logic                  crc_en_q, hdr_match, hdr_good, xfer, last_byte, crc_clr, crc_upd;

   assign hdr_len  = data_in[SIZE_WIDTH-1:0];
   assign hdr_addr = data_in[SIZE_WIDTH+ADDR_WIDTH-1:SIZE_WIDTH];

   // Descending scan so the lowest matching channel wins.
   always_comb begin
      hdr_match = 1'b0;
      sel_dec   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == hdr_addr) begin
            hdr_match = 1'b1;
            sel_dec   = SEL_W'(i);
         end
      end
   end

   assign hdr_good     = hdr_match && (hdr_len != '0);
   assign sel_cur      = (state == ST_IDLE) ? sel_dec : sel_q;
   assign data_in_ack  = (state == ST_DISCARD) ? 1'b1 : !fifo_full[sel_cur];
   assign xfer         = data_in_req & data_in_ack;
   assign ch_onehot    = NUM_CH'(1) << sel_cur;
   assign last_byte    = (cnt == CNT_W'(1));
   assign cnt_load     = CNT_W'(hdr_len) + CNT_W'(crc_en);
   assign fifo_data_in = data_in;
   assign drop_cause   = cause;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: if (xfer) begin
            if (hdr_good) begin
               state_nxt = ST_DATA;
               cnt_nxt   = CNT_W'(hdr_len);
            end else begin
               cnt_nxt = cnt_load;
               if (cnt_load != '0) state_nxt = ST_DISCARD;
            end
         end
         ST_DATA: if (xfer) begin
            cnt_nxt = cnt - CNT_W'(1);
            if (last_byte) state_nxt = crc_en_q ? ST_CRC : ST_IDLE;
         end
         ST_CRC: if (xfer) state_nxt = ST_IDLE;
         ST_DISCARD: if (xfer) begin
            cnt_nxt = cnt - CNT_W'(1);
            if (last_byte) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      fifo_push       = '0;
      fifo_flush      = '0;
      fifo_wr_ptr_upd = '0;
      pkt_ok          = 1'b0;
      pkt_drop        = 1'b0;
      cause           = CAUSE_NO_MATCH;
      crc_clr         = 1'b0;
      crc_upd         = 1'b0;
      case (state)
         ST_IDLE: if (xfer) begin
            crc_clr = 1'b1;
            crc_upd = 1'b1;
            if (hdr_good) begin
               fifo_push = ch_onehot;
            end else begin
               pkt_drop = 1'b1;
               cause    = hdr_match ? CAUSE_BAD_LEN : CAUSE_NO_MATCH;
            end
         end
         ST_DATA: if (xfer) begin
            fifo_push = ch_onehot;
            crc_upd   = 1'b1;
            if (last_byte && !crc_en_q) begin
               fifo_wr_ptr_upd = ch_onehot;
               pkt_ok          = 1'b1;
            end
         end
         ST_CRC: if (xfer) begin
            if (data_in == crc_val) begin
               fifo_wr_ptr_upd = ch_onehot;
               pkt_ok          = 1'b1;
            end else begin
               fifo_flush = ch_onehot;
               pkt_drop   = 1'b1;
               cause      = CAUSE_BAD_CRC;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         sel_q    <= '0;
         crc_en_q <= 1'b0;
         drop_cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
         if (state == ST_IDLE && xfer) begin
            sel_q    <= sel_dec;
            crc_en_q <= crc_en;
         end
         if (pkt_drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
   end

   crc_serial #(
      .WIDTH (DATA_WIDTH),
      .POLY  (CRC_POLY)
   ) u_crc (
      .clk  (clk),
      .rst  (rst),
      .clr  (crc_clr),
      .en   (crc_upd),
      .data (data_in),
      .crc  (crc_val)
   );

endmodule

// File: tb/tb_pkt_ingress.sv
// Self-checking bench for pkt_ingress: directed scenarios plus randomized packets
// compared against a packet-level reference model.
module tb_pkt_ingress;

   localparam int NC  = 3;
   localparam int DCW = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [7:0]     data_in;
   logic           data_in_req;
   logic           data_in_ack;
   logic [NC-1:0]  fifo_push, fifo_flush, fifo_wr_ptr_upd, fifo_full;
   logic [7:0]     fifo_data_in;
   logic [2*NC-1:0] ch_addr;
   logic           crc_en;
   logic           pkt_ok, pkt_drop;
   logic [1:0]     drop_cause;
   logic [DCW-1:0] drop_cnt;

   pkt_ingress #(
      .DATA_WIDTH (8), .SIZE_WIDTH (6), .ADDR_WIDTH (2), .NUM_CH (NC),
      .CRC_POLY (8'h07), .DROP_CNT_W (DCW)
   ) dut (
      .clk (clk), .rst (rst), .data_in (data_in), .data_in_req (data_in_req),
      .data_in_ack (data_in_ack), .fifo_push (fifo_push), .fifo_flush (fifo_flush),
      .fifo_wr_ptr_upd (fifo_wr_ptr_upd), .fifo_full (fifo_full),
      .fifo_data_in (fifo_data_in), .ch_addr (ch_addr), .crc_en (crc_en),
      .pkt_ok (pkt_ok), .pkt_drop (pkt_drop), .drop_cause (drop_cause),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor: what the DUT actually wrote/committed/dropped
   logic [7:0] got_q[NC][$];
   int upd_cnt[NC], flush_cnt[NC];
   int ok_cnt, drop_ev, onehot_bad, xfer_cnt, stall_bad;
   logic [1:0] last_cause;

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NC; i++) begin
            if (fifo_push[i])       got_q[i].push_back(fifo_data_in);
            if (fifo_wr_ptr_upd[i]) upd_cnt[i]++;
            if (fifo_flush[i])      flush_cnt[i]++;
         end
         if (pkt_ok) ok_cnt++;
         if (pkt_drop) begin drop_ev++; last_cause = drop_cause; end
         if (data_in_req && data_in_ack) xfer_cnt++;
         if ($countones(fifo_push) > 1 || $countones(fifo_flush) > 1 ||
             $countones(fifo_wr_ptr_upd) > 1 || (fifo_flush & fifo_wr_ptr_upd) != '0)
            onehot_bad++;
      end
   end

   task automatic clear_mon();
      for (int i = 0; i < NC; i++) begin
         got_q[i].delete(); upd_cnt[i] = 0; flush_cnt[i] = 0;
      end
      ok_cnt = 0; drop_ev = 0; xfer_cnt = 0; stall_bad = 0; last_cause = 2'b11;
   endtask

   function automatic int tot_push();
      int s = 0;
      for (int i = 0; i < NC; i++) s += got_q[i].size();
      return s;
   endfunction

   function automatic int tot_upd();
      int s = 0;
      for (int i = 0; i < NC; i++) s += upd_cnt[i];
      return s;
   endfunction

   function automatic int tot_flush();
      int s = 0;
      for (int i = 0; i < NC; i++) s += flush_cnt[i];
      return s;
   endfunction

   // Reference model state
   logic [7:0] pl[$];
   logic [7:0] e_q[$];
   int         e_ch, e_ok, e_drop, e_flush, e_upd, drop_model;
   logic [1:0] e_cause;

   function automatic logic [7:0] crc8(input logic [7:0] msg[$]);
      logic [7:0] c = 8'h00;
      foreach (msg[k]) begin
         for (int b = 7; b >= 0; b--) begin
            logic fb = c[7] ^ msg[k][b];
            c = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
         end
      end
      return c;
   endfunction

   function automatic bit q_match(input int ch);
      if (ch < 0) return 1'b0;
      if (got_q[ch].size() != e_q.size()) return 1'b0;
      foreach (e_q[k]) if (got_q[ch][k] !== e_q[k]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      bit done = 1'b0;
      data_in     = b;
      data_in_req = 1'b1;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge clk);
         if (data_in_ack) done = 1'b1;
         @(posedge clk); #1;
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL ack_timeout: byte %02h ack stayed 0 for 40 cycles, required 1", b);
      end
   endtask

   // Sends header + pl[0..L-1] + optional CRC, and fills the model expectations.
   task automatic send_packet(input logic [7:0] hdr, input bit bad_crc, input bit scramble,
                              input bit full_body, input int stall_at);
      logic [7:0] msg[$];
      logic [7:0] bytes[$];
      logic [7:0] c;
      int   L  = int'(hdr[5:0]);
      logic ce = crc_en;
      int   ch = -1;
      for (int i = NC - 1; i >= 0; i--) if (ch_addr[i*2 +: 2] == hdr[7:6]) ch = i;
      msg.push_back(hdr);
      for (int k = 0; k < L; k++) msg.push_back(pl[k]);
      c = crc8(msg);
      if (bad_crc) c = c ^ 8'h5A;
      e_ch = ch; e_q.delete(); e_ok = 0; e_drop = 0; e_flush = 0; e_upd = 0; e_cause = 2'b00;
      if (ch >= 0 && L != 0) begin
         e_q = msg;
         if (!ce || !bad_crc) begin e_ok = 1; e_upd = 1; end
         else begin e_drop = 1; e_flush = 1; e_cause = 2'b10; end
      end else begin
         e_drop  = 1;
         e_cause = (ch >= 0) ? 2'b01 : 2'b00;
      end
      if (e_drop != 0 && drop_model < (1 << DCW) - 1) drop_model++;
      bytes = msg;
      if (ce) bytes.push_back(c);
      foreach (bytes[k]) begin
         if (k == 1 && scramble) begin
            ch_addr = 6'($urandom);
            crc_en  = 1'($urandom);
         end
         if (k == 1 && full_body) fifo_full = '1;
         if (k == stall_at) begin
            data_in = bytes[k]; data_in_req = 1'b1; fifo_full = 3'b010;
            repeat (4) begin
               @(negedge clk);
               if (data_in_ack) stall_bad++;
               @(posedge clk); #1;
            end
            fifo_full = '0;
         end
         send_byte(bytes[k]);
      end
      if (full_body) fifo_full = '0;
   endtask

   task automatic fill_payload(input int n);
      pl.delete();
      for (int k = 0; k < n; k++) pl.push_back(8'($urandom));
   endtask

   task automatic test_reset();
      rst = 1'b1; data_in = '0; data_in_req = 1'b0; fifo_full = '0;
      ch_addr = {2'd2, 2'd1, 2'd0}; crc_en = 1'b0; drop_model = 0;
      clear_mon();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({fifo_push, fifo_flush, fifo_wr_ptr_upd, pkt_ok, pkt_drop} !== '0) begin
         n_fail++;
         $display("FAIL reset_strobes: got %b, required all zero",
                  {fifo_push, fifo_flush, fifo_wr_ptr_upd, pkt_ok, pkt_drop});
      end
      n_checks++;
      if (drop_cnt !== '0) begin
         n_fail++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt);
      end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (data_in_ack !== 1'b1) begin
         n_fail++; $display("FAIL reset_ack: got %b, required 1", data_in_ack);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      clear_mon(); crc_en = 1'b0; ch_addr = {2'd2, 2'd1, 2'd0};
      pl = '{8'hA1, 8'hB2, 8'hC3};
      send_packet(8'h43, 1'b0, 1'b0, 1'b0, -1);
      n_checks++;
      if (!q_match(1) || tot_push() != 4) begin
         n_fail++; $display("FAIL basic_push: ch1 got %0d bytes (total %0d), required 4 in order",
                            got_q[1].size(), tot_push());
      end
      n_checks++;
      if (upd_cnt[1] != 1 || tot_upd() != 1 || ok_cnt != 1) begin
         n_fail++; $display("FAIL basic_commit: upd1=%0d ok=%0d, required 1 and 1", upd_cnt[1], ok_cnt);
      end
   endtask

   task automatic test_crc();
      clear_mon(); crc_en = 1'b1; ch_addr = {2'd2, 2'd1, 2'd0};
      pl = '{8'h11, 8'h22};
      send_packet(8'h02, 1'b0, 1'b0, 1'b0, -1);
      n_checks++;
      if (!q_match(0) || tot_push() != 3 || upd_cnt[0] != 1 || ok_cnt != 1 || tot_flush() != 0) begin
         n_fail++; $display("FAIL crc_good: push0=%0d upd0=%0d ok=%0d flush=%0d, required 3/1/1/0",
                            got_q[0].size(), upd_cnt[0], ok_cnt, tot_flush());
      end
      clear_mon();
      send_packet(8'h02, 1'b1, 1'b0, 1'b0, -1);
      n_checks++;
      if (flush_cnt[0] != 1 || tot_upd() != 0 || drop_ev != 1 || last_cause !== 2'b10) begin
         n_fail++; $display("FAIL crc_bad: flush0=%0d upd=%0d drops=%0d cause=%b, required 1/0/1/10",
                            flush_cnt[0], tot_upd(), drop_ev, last_cause);
      end
      n_checks++;
      if (drop_cnt !== DCW'(drop_model) || drop_model != 1) begin
         n_fail++; $display("FAIL crc_drop_cnt: got %0d, required 1", drop_cnt);
      end
   endtask

   task automatic test_discard_back_to_back();
      clear_mon(); crc_en = 1'b1; ch_addr = {2'd2, 2'd1, 2'd0};
      fill_payload(5);
      send_packet(8'hC5, 1'b0, 1'b0, 1'b1, -1);
      n_checks++;
      if (xfer_cnt != 7 || tot_push() != 0 || drop_ev != 1 || last_cause !== 2'b00) begin
         n_fail++; $display("FAIL discard: acked=%0d pushes=%0d drops=%0d cause=%b, required 7/0/1/00",
                            xfer_cnt, tot_push(), drop_ev, last_cause);
      end
      clear_mon();
      pl = '{8'h5C};
      send_packet(8'h41, 1'b0, 1'b0, 1'b0, -1);
      n_checks++;
      if (!q_match(1) || tot_push() != 2 || upd_cnt[1] != 1 || ok_cnt != 1) begin
         n_fail++; $display("FAIL back_to_back: push1=%0d upd1=%0d ok=%0d, required 2/1/1",
                            got_q[1].size(), upd_cnt[1], ok_cnt);
      end
      clear_mon(); crc_en = 1'b0; ch_addr = {2'd2, 2'd1, 2'd0};
      pl.delete();
      send_packet(8'h40, 1'b0, 1'b0, 1'b0, -1);
      n_checks++;
      if (tot_push() != 0 || drop_ev != 1 || last_cause !== 2'b01) begin
         n_fail++; $display("FAIL zero_len: pushes=%0d drops=%0d cause=%b, required 0/1/01",
                            tot_push(), drop_ev, last_cause);
      end
   endtask

   task automatic test_backpressure();
      clear_mon(); crc_en = 1'b0; ch_addr = {2'd2, 2'd1, 2'd0};
      fill_payload(5);
      send_packet(8'h45, 1'b0, 1'b0, 1'b0, 2);
      n_checks++;
      if (stall_bad != 0) begin
         n_fail++; $display("FAIL stall_ack: ack high in %0d stalled cycles, required 0", stall_bad);
      end
      n_checks++;
      if (!q_match(1) || tot_push() != 6 || upd_cnt[1] != 1) begin
         n_fail++; $display("FAIL stall_order: push1=%0d upd1=%0d, required 6 in order and 1",
                            got_q[1].size(), upd_cnt[1]);
      end
   endtask

   task automatic test_dup_addr();
      clear_mon(); crc_en = 1'b0; ch_addr = {2'd1, 2'd3, 2'd1};
      fill_payload(2);
      send_packet(8'h42, 1'b0, 1'b0, 1'b0, -1);
      n_checks++;
      if (!q_match(0) || got_q[2].size() != 0 || upd_cnt[0] != 1) begin
         n_fail++; $display("FAIL dup_addr: push0=%0d push2=%0d upd0=%0d, required 3/0/1",
                            got_q[0].size(), got_q[2].size(), upd_cnt[0]);
      end
   endtask

   task automatic test_random();
      for (int p = 0; p < 24; p++) begin
         logic [7:0] hdr;
         clear_mon();
         if (p % 4 == 0) begin
            ch_addr = 6'($urandom);
            crc_en  = 1'($urandom);
         end
         hdr = {2'($urandom), 6'($urandom_range(0, 6))};
         fill_payload(int'(hdr[5:0]));
         send_packet(hdr, 1'($urandom), 1'b1, 1'b0, -1);
         n_checks++;
         if (tot_push() != e_q.size() || (e_q.size() != 0 && !q_match(e_ch))) begin
            n_fail++; $display("FAIL rand_push[%0d]: hdr=%02h got %0d pushes, required %0d on ch %0d",
                               p, hdr, tot_push(), e_q.size(), e_ch);
         end
         n_checks++;
         if (ok_cnt != e_ok || tot_upd() != e_upd || tot_flush() != e_flush || drop_ev != e_drop) begin
            n_fail++; $display("FAIL rand_outcome[%0d]: ok/upd/flush/drop=%0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
                               p, ok_cnt, tot_upd(), tot_flush(), drop_ev, e_ok, e_upd, e_flush, e_drop);
         end
         n_checks++;
         if ((e_drop != 0 && last_cause !== e_cause) || drop_cnt !== DCW'(drop_model)) begin
            n_fail++; $display("FAIL rand_cause[%0d]: cause=%b cnt=%0d, required %b and %0d",
                               p, last_cause, drop_cnt, e_cause, drop_model);
         end
      end
   endtask

   task automatic test_reset_mid_packet();
      clear_mon(); crc_en = 1'b0; ch_addr = {2'd2, 2'd1, 2'd0};
      send_byte(8'h45);
      send_byte(8'h01);
      send_byte(8'h02);
      data_in_req = 1'b0;
      rst = 1'b1; drop_model = 0;
      @(negedge clk);
      n_checks++;
      if ({fifo_push, fifo_flush, fifo_wr_ptr_upd, pkt_ok, pkt_drop} !== '0 || drop_cnt !== '0) begin
         n_fail++; $display("FAIL rst_mid: strobes=%b cnt=%0d, required zero",
                            {fifo_push, fifo_flush, fifo_wr_ptr_upd, pkt_ok, pkt_drop}, drop_cnt);
      end
      @(posedge clk); #1; rst = 1'b0;
      n_checks++;
      if (tot_flush() != 0 || tot_upd() != 0) begin
         n_fail++; $display("FAIL rst_no_flush: flush=%0d upd=%0d, required 0/0", tot_flush(), tot_upd());
      end
      clear_mon();
      pl = '{8'h77, 8'h88};
      send_packet(8'h42, 1'b0, 1'b0, 1'b0, -1);
      n_checks++;
      if (!q_match(1) || tot_push() != 3 || upd_cnt[1] != 1) begin
         n_fail++; $display("FAIL rst_recover: push1=%0d upd1=%0d, required 3/1", got_q[1].size(), upd_cnt[1]);
      end
   endtask

   task automatic test_saturation();
      clear_mon(); crc_en = 1'b0; ch_addr = {2'd2, 2'd1, 2'd0};
      pl.delete();
      for (int k = 0; k < (1 << DCW) + 2; k++) send_packet(8'hC0, 1'b0, 1'b0, 1'b0, -1);
      n_checks++;
      if (drop_ev != (1 << DCW) + 2) begin
         n_fail++; $display("FAIL sat_events: got %0d drops, required %0d", drop_ev, (1 << DCW) + 2);
      end
      n_checks++;
      if (drop_cnt !== DCW'(drop_model) || drop_model != (1 << DCW) - 1) begin
         n_fail++; $display("FAIL sat_cnt: got %0d, required %0d", drop_cnt, (1 << DCW) - 1);
      end
   endtask

   initial begin
      onehot_bad = 0;
      test_reset();
      test_basic();
      test_crc();
      test_discard_back_to_back();
      test_backpressure();
      test_dup_addr();
      test_random();
      test_reset_mid_packet();
      test_saturation();
      data_in_req = 1'b0;
      repeat (2) @(posedge clk);
      n_checks++;
      if (onehot_bad != 0) begin
         n_fail++; $display("FAIL onehot: %0d cycles with multiple strobes, required 0", onehot_bad);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
